// File: rtl/cla_ctrl_pkg.sv
// Shared constants and types for the nibble-serial adder: slice width,
// FSM state encoding and the elaboration-time WIDTH check.

`ifndef CLA_CTRL_PKG_SV
`define CLA_CTRL_PKG_SV

package cla_ctrl_pkg;

    // Width of the time-shared carry-look-ahead slice.
    localparam int NIBBLE_W = 4;

    // Sequencer states. Encodings are fixed so debug taps stay stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// Rejects any WIDTH that cannot be split into whole nibbles.
`define CLA_CTRL_WIDTH_CHECK(w) \
    if ((((w) % 4) != 0) || ((w) < 4)) begin : g_width_check \
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4"); \
    end

`endif

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-look-ahead adder slice. Purely combinational; all four carries
// are computed in parallel from generate/propagate terms.

module nibble_serial_adder_cla4
    import cla_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[NIBBLE_W-1:0];
    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble
// per clock, least significant nibble first. The carry between nibbles is
// held in a register.
//
// Handshake: start is sampled only while idle (busy=0); the accepting edge
// captures inp_a, inp_b and CarryIN. busy stays high through RUN and DONE and
// any start seen then is dropped. done is a one-cycle pulse during which SUM
// and CarryOUT hold the new result; they then hold until the next completion.

module nibble_serial_adder
    import cla_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic             CarryIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             CarryOUT,
    output logic [1:0]       dbg_state
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    // A single-nibble build still gets a 1-bit counter.
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    `CLA_CTRL_WIDTH_CHECK(WIDTH)

    state_t                             state;
    logic [CNT_W-1:0]                   cnt;
    logic                               carry_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   acc;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   acc_upd;
    logic [NIBBLE_W-1:0]                slice_sum;
    logic                               slice_cout;

    assign dbg_state = state;

    nibble_serial_adder_cla4 u_slice (
        .a    (a_reg[cnt]),
        .b    (b_reg[cnt]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Accumulator with the current nibble merged in; on the last RUN edge
    // this is the complete result, so SUM never sees a partial value.
    always_comb begin
        acc_upd      = acc;
        acc_upd[cnt] = slice_sum;
    end

    // Sequencer: capture on accept, one nibble per RUN edge, one DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            SUM       <= '0;
            CarryOUT  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= inp_a;
                        b_reg     <= inp_b;
                        carry_reg <= CarryIN;
                        cnt       <= '0;
                        acc       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc       <= acc_upd;
                    carry_reg <= slice_cout;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_NIB) begin
                        SUM      <= acc_upd;
                        CarryOUT <= slice_cout;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
